// File: rtl/conv_seq_pkg.sv
// Shared definitions for the conv_seq sequencer: state encoding, fp16
// constants, default parameters and the fp16 helper functions.
package conv_seq_pkg;

    localparam int          CH_W_DEF    = 8;
    localparam int          TIMEOUT_DEF = 1023;
    localparam logic [15:0] FP16_ZERO   = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CONV  = 3'd2,
        ST_ADD   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // ReLU on an fp16 value: negative results collapse to +0.
    function automatic logic [15:0] fp16_relu(input logic relu, input logic [15:0] v);
        logic [15:0] r;
        if (relu && v[15]) begin
            r = FP16_ZERO;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // fp16 addition, round-to-nearest-even, subnormals supported.
    // Inf/NaN operands are passed through from the larger-magnitude input.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, r;
        logic [4:0]  ex, ey;
        logic [13:0] mx, my, sh;
        logic [14:0] s;
        logic [6:0]  e, d;
        logic [11:0] m;
        logic        sticky, rnd;
        // x always carries the larger magnitude so the alignment shift is one-sided
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
        my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
        d  = {2'b00, ex - ey};
        if (d > 7'd13) begin
            sh     = 14'd0;
            sticky = |my;
        end else begin
            sh     = my >> d;
            sticky = |(my & ~(14'h3fff << d));
        end
        sh[0] = sh[0] | sticky;
        if (x[15] == y[15]) begin
            s = {1'b0, mx} + {1'b0, sh};
        end else begin
            s = {1'b0, mx} - {1'b0, sh};
        end
        e = {2'b00, ex};
        if (s[14]) begin
            s = {1'b0, s[14:1]} | {14'd0, s[0]};
            e = e + 7'd1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!s[13] && (e > 7'd1)) begin
                    s = s << 1;
                    e = e - 7'd1;
                end else begin
                    s = s;
                end
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[13:3]} + {11'd0, rnd};
        if (m[11]) begin
            m = m >> 1;
            e = e + 7'd1;
        end else begin
            m = m;
        end
        if (x[14:10] == 5'h1f) begin
            r = x;
        end else if (s == 15'd0) begin
            r = FP16_ZERO;
        end else if (e >= 7'd31) begin
            r = {x[15], 5'h1f, 10'd0};
        end else begin
            r = {x[15], (m[10] ? e[4:0] : 5'd0), m[9:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_seq_if.sv
// Job / fetch / engine / result signal bundle of the conv sequencer.
// master = sequencer side, slave = environment (job source, operand
// fetcher, conv engine and result consumer).
interface conv_seq_if import conv_seq_pkg::*; #(
    parameter int CH_W = CH_W_DEF
);
    logic            job_valid;
    logic            job_ready;
    logic [CH_W-1:0] job_channels;
    logic            job_relu;
    logic            fetch_req;
    logic [CH_W-1:0] fetch_ch;
    logic            fetch_ack;
    logic            eng_start;
    logic            eng_done;
    logic [15:0]     eng_result;
    logic            res_valid;
    logic            res_ready;
    logic [15:0]     res_data;
    logic            busy;
    logic            err;

    modport master (
        input  job_valid, job_channels, job_relu, fetch_ack, eng_done, eng_result, res_ready,
        output job_ready, fetch_req, fetch_ch, eng_start, res_valid, res_data, busy, err
    );

    modport slave (
        output job_valid, job_channels, job_relu, fetch_ack, eng_done, eng_result, res_ready,
        input  job_ready, fetch_req, fetch_ch, eng_start, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/conv_psum_add.sv
// Partial-sum adder: wraps a one-shot fp16 accumulate core. A one-cycle nd
// loads a+b; rdy pulses for one cycle with the sum, then the core clears.
module conv_psum_add import conv_seq_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        nd,
    output logic        rdy,
    output logic [15:0] result
);
    logic        ce_s;
    logic        sclr_s;
    logic        rdy_q;
    logic [15:0] result_q;

    // The core only advances while no result is pending and self-clears
    // in the cycle after it presents one.
    assign ce_s   = ~rdy_q;
    assign sclr_s = rdy_q;

    // Accumulate core: capture the sum on nd, present it for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            result_q <= FP16_ZERO;
        end else if (sclr_s) begin
            rdy_q    <= 1'b0;
            result_q <= FP16_ZERO;
        end else if (ce_s) begin
            rdy_q    <= nd;
            result_q <= nd ? fp16_add(a, b) : result_q;
        end else begin
            rdy_q    <= rdy_q;
            result_q <= result_q;
        end
    end

    assign rdy    = rdy_q;
    assign result = result_q;
endmodule

// File: rtl/conv_seq.sv
// Convolution channel sequencer: for each input channel fetches operands,
// starts the 3x3 engine, and accumulates the fp16 results; the channel sum
// (optionally ReLU'd) is then offered on the result port. A watchdog aborts
// a job that waits too long on the engine or adder.
module conv_seq import conv_seq_pkg::*; #(
    parameter int CH_W    = CH_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic        clk,
    input logic        rst_n,
    conv_seq_if.master bus
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);

    state_t          state_q;
    logic [CH_W-1:0] ch_total_q;
    logic [CH_W-1:0] ch_cnt_q;
    logic            relu_q;
    logic [15:0]     psum_q;
    logic [15:0]     add_b_q;
    logic            add_nd_q;
    logic [WD_W-1:0] wdog_q;
    logic            job_ready_q;
    logic            fetch_req_q;
    logic            eng_start_q;
    logic            res_valid_q;
    logic [15:0]     res_data_q;
    logic            busy_q;
    logic            err_q;

    logic            last_ch_s;
    logic            wd_expired_s;
    logic            add_rdy_s;
    logic [15:0]     add_result_s;

    // ch_total is at least 1 whenever this is consulted, so the subtraction
    // never wraps and the counter stops at the last channel.
    assign last_ch_s    = (ch_cnt_q == (ch_total_q - CH_ONE));
    assign wd_expired_s = (wdog_q == WD_LAST);

    conv_psum_add u_add (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (psum_q),
        .b      (add_b_q),
        .nd     (add_nd_q),
        .rdy    (add_rdy_s),
        .result (add_result_s)
    );

    // Sequencer FSM with registered outputs; the watchdog restarts from zero
    // on every transition and only counts while waiting in CONV or ADD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ch_total_q  <= '0;
            ch_cnt_q    <= '0;
            relu_q      <= 1'b0;
            psum_q      <= FP16_ZERO;
            add_b_q     <= FP16_ZERO;
            add_nd_q    <= 1'b0;
            wdog_q      <= '0;
            job_ready_q <= 1'b0;
            fetch_req_q <= 1'b0;
            eng_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= FP16_ZERO;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            add_nd_q    <= 1'b0;
            wdog_q      <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.job_valid && job_ready_q) begin
                        ch_total_q  <= bus.job_channels;
                        relu_q      <= bus.job_relu;
                        ch_cnt_q    <= '0;
                        err_q       <= 1'b0;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.job_channels == '0) begin
                            psum_q      <= FP16_ZERO;
                            res_data_q  <= FP16_ZERO;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else begin
                            fetch_req_q <= 1'b1;
                            state_q     <= ST_FETCH;
                        end
                    end else begin
                        job_ready_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (bus.fetch_ack) begin
                        fetch_req_q <= 1'b0;
                        eng_start_q <= 1'b1;
                        state_q     <= ST_CONV;
                    end else begin
                        fetch_req_q <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (bus.eng_done) begin
                        if (ch_cnt_q == '0) begin
                            psum_q <= bus.eng_result;
                            if (last_ch_s) begin
                                res_data_q  <= fp16_relu(relu_q, bus.eng_result);
                                res_valid_q <= 1'b1;
                                state_q     <= ST_OUT;
                            end else begin
                                ch_cnt_q    <= ch_cnt_q + CH_ONE;
                                fetch_req_q <= 1'b1;
                                state_q     <= ST_FETCH;
                            end
                        end else begin
                            add_b_q  <= bus.eng_result;
                            add_nd_q <= 1'b1;
                            state_q  <= ST_ADD;
                        end
                    end else if (wd_expired_s) begin
                        err_q       <= 1'b1;
                        res_data_q  <= FP16_ZERO;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        wdog_q <= wdog_q + WD_ONE;
                    end
                end
                ST_ADD: begin
                    if (add_rdy_s) begin
                        psum_q <= add_result_s;
                        if (last_ch_s) begin
                            res_data_q  <= fp16_relu(relu_q, add_result_s);
                            res_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else begin
                            ch_cnt_q    <= ch_cnt_q + CH_ONE;
                            fetch_req_q <= 1'b1;
                            state_q     <= ST_FETCH;
                        end
                    end else if (wd_expired_s) begin
                        err_q       <= 1'b1;
                        res_data_q  <= FP16_ZERO;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        wdog_q <= wdog_q + WD_ONE;
                    end
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        job_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        res_valid_q <= 1'b1;
                    end
                end
                default: begin
                    fetch_req_q <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    job_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.job_ready = job_ready_q;
    assign bus.fetch_req = fetch_req_q;
    assign bus.fetch_ch  = ch_cnt_q;
    assign bus.eng_start = eng_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_conv_seq.sv
// Self-checking bench for conv_seq. Engine results are integer-valued fp16
// numbers so every channel sum is exact; the reference is the plain integer
// sum of the channel values, ReLU'd and encoded to fp16.
module tb_conv_seq;
    localparam int CH_W = 8;
    localparam int TO   = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   vals[$];

    conv_seq_if #(.CH_W(CH_W)) bus ();

    conv_seq #(.CH_W(CH_W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Integer to fp16 (exact for |v| < 2048).
    function automatic logic [15:0] int_to_fp16(input int v);
        int mag;
        int p;
        if (v == 0) return 16'h0000;
        mag = (v < 0) ? -v : v;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        return {((v < 0) ? 1'b1 : 1'b0), 5'(p + 15), 10'(mag << (10 - p))};
    endfunction

    function automatic bit cur(input int sel);
        case (sel)
            0: return bus.fetch_req;
            1: return bus.res_valid;
            2: return bus.job_ready;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (cur(sel)) seen = 1'b1;
            else @(negedge clk);
        end
        chk(tag, seen, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_job_ready"}, bus.job_ready, 0);
        chk({tag, "_fetch_req"}, bus.fetch_req, 0);
        chk({tag, "_fetch_ch"},  bus.fetch_ch, 0);
        chk({tag, "_eng_start"}, bus.eng_start, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_data"},  bus.res_data, 0);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_err"},       bus.err, 0);
    endtask

    task automatic start_job(input int nch, input bit relu);
        wait_for("job_ready_wait", 2);
        bus.job_valid    = 1'b1;
        bus.job_channels = CH_W'(nch);
        bus.job_relu     = relu;
        @(negedge clk);
        bus.job_valid = 1'b0;
        chk("accept_busy", bus.busy, 1);
        chk("accept_job_ready", bus.job_ready, 0);
        chk("accept_err", bus.err, 0);
    endtask

    task automatic do_channel(input int idx, input logic [15:0] res, input int dly);
        wait_for("fetch_req_wait", 0);
        chk("fetch_ch", bus.fetch_ch, idx);
        repeat ($urandom_range(2, 0)) @(negedge clk);
        bus.fetch_ack = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        chk("eng_start_pulse", bus.eng_start, 1);
        chk("fetch_req_drop", bus.fetch_req, 0);
        @(negedge clk);
        chk("eng_start_one_cycle", bus.eng_start, 0);
        repeat (dly) @(negedge clk);
        bus.eng_done   = 1'b1;
        bus.eng_result = res;
        @(negedge clk);
        bus.eng_done   = 1'b0;
        bus.eng_result = 16'($urandom);
    endtask

    task automatic finish_job(input logic [15:0] exp_data, input bit exp_err, input int hold);
        wait_for("res_valid_wait", 1);
        chk("res_data", bus.res_data, exp_data);
        chk("res_err", bus.err, exp_err);
        repeat (hold) @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("res_done_valid", bus.res_valid, 0);
        chk("res_done_busy", bus.busy, 0);
    endtask

    // Runs a full job using the channel values in vals.
    task automatic run_job(input int nch, input bit relu);
        int sum = 0;
        logic [15:0] exp_data;
        foreach (vals[i]) sum += vals[i];
        exp_data = (relu && sum < 0) ? 16'h0000 : int_to_fp16(sum);
        start_job(nch, relu);
        for (int i = 0; i < nch; i++) do_channel(i, int_to_fp16(vals[i]), $urandom_range(3, 0));
        if (nch == 1) chk("lat_single_channel", bus.res_valid, 1);
        finish_job(exp_data, 1'b0, $urandom_range(3, 0));
    endtask

    initial begin
        logic [15:0] snap;
        bit stable;
        bus.job_valid = 1'b0; bus.job_channels = '0; bus.job_relu = 1'b0;
        bus.fetch_ack = 1'b0; bus.eng_done = 1'b0; bus.eng_result = 16'h0000;
        bus.res_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_fetch_req", bus.fetch_req, 0);
        chk("post_rst_eng_start", bus.eng_start, 0);
        chk("post_rst_res_valid", bus.res_valid, 0);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_job_ready", bus.job_ready, 1);

        // stray engine completion while idle
        bus.eng_done = 1'b1; bus.eng_result = 16'h1234;
        @(negedge clk);
        bus.eng_done = 1'b0;
        chk("stray_done_valid", bus.res_valid, 0);
        chk("stray_done_busy", bus.busy, 0);

        vals = '{1};         run_job(1, 1'b0);
        vals = '{1, 1, 1};   run_job(3, 1'b0);
        vals = '{-1, -1};    run_job(2, 1'b1);
        vals = '{-1, -1};    run_job(2, 1'b0);

        // zero-channel job
        start_job(0, 1'b0);
        chk("zero_ch_no_fetch", bus.fetch_req, 0);
        finish_job(16'h0000, 1'b0, 0);

        // result held with res_ready low, new job offered meanwhile
        start_job(1, 1'b0);
        do_channel(0, int_to_fp16(5), 1);
        wait_for("hold_valid_wait", 1);
        snap = bus.res_data;
        stable = 1'b1;
        bus.job_valid = 1'b1; bus.job_channels = CH_W'(1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.res_data !== snap || !bus.res_valid || bus.job_ready) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        chk("hold_data", bus.res_data, int_to_fp16(5));
        bus.job_valid = 1'b0; bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("hold_accept_first", bus.res_valid, 0);

        // watchdog expiry with eng_done withheld
        start_job(1, 1'b0);
        wait_for("to_fetch_wait", 0);
        bus.fetch_ack = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        chk("to_conv_entry", bus.eng_start, 1);
        for (int n = 1; n <= TO; n++) begin
            @(negedge clk);
            if (n == TO - 1) begin
                chk("to_pre_err", bus.err, 0);
                chk("to_pre_valid", bus.res_valid, 0);
            end
        end
        chk("to_err", bus.err, 1);
        chk("to_valid", bus.res_valid, 1);
        chk("to_data", bus.res_data, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("to_err_sticky", bus.err, 1);

        // eng_done on the very expiry cycle wins
        start_job(1, 1'b0);
        wait_for("tb_fetch_wait", 0);
        bus.fetch_ack = 1'b1;
        @(negedge clk);
        bus.fetch_ack = 1'b0;
        for (int n = 1; n < TO; n++) @(negedge clk);
        bus.eng_done = 1'b1; bus.eng_result = int_to_fp16(3);
        @(negedge clk);
        bus.eng_done = 1'b0;
        chk("edge_done_valid", bus.res_valid, 1);
        chk("edge_done_err", bus.err, 0);
        chk("edge_done_data", bus.res_data, int_to_fp16(3));
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;

        // reset while the adder is working
        start_job(2, 1'b0);
        do_channel(0, int_to_fp16(1), 0);
        do_channel(1, int_to_fp16(1), 0);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("mid_add_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vals = '{2};         run_job(1, 1'b0);

        // widest job the counter allows
        vals.delete();
        for (int i = 0; i < 255; i++) vals.push_back(1);
        run_job(255, 1'b0);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            int nch;
            nch = $urandom_range(6, 1);
            vals.delete();
            for (int i = 0; i < nch; i++) vals.push_back(int'($urandom_range(16, 0)) - 8);
            run_job(nch, 1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/conv_seq.md
CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 Parameter CH_W, default 8: width of the channel counter and of job_channels/fetch_ch.
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles to wait for eng_done or add_rdy before aborting.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 job_valid  in  1  job offered.
REQ-006 job_ready  out  1  sequencer can accept a job.
REQ-007 job_channels  in  CH_W  input-channel count for the job; sampled on accept.
REQ-008 job_relu  in  1  apply ReLU to the final sum; sampled on accept.
REQ-009 fetch_req  out  1  request that the im/iw operands for channel fetch_ch be placed on the engine inputs.
REQ-010 fetch_ch  out  CH_W  channel index being fetched.
REQ-011 fetch_ack  in  1  operands are stable on the engine inputs.
REQ-012 eng_start  out  1  one-cycle start pulse to the 3x3 conv engine.
REQ-013 eng_done  in  1  one-cycle engine completion pulse.
REQ-014 eng_result  in  16  fp16 engine result; valid with eng_done.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts the result.
REQ-017 res_data  out  16  fp16 channel-summed, optionally ReLU'd, result.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 err  out  1  sticky timeout flag; cleared on the next job accept.

Function
REQ-020 States: IDLE, FETCH, CONV, ADD, OUT.
REQ-021 IDLE: job_ready=1; on job_valid&job_ready, latch channels and relu, set ch_cnt=0, clear err, go to FETCH next cycle.
REQ-022 A job with job_channels=0 goes directly to OUT with res_data=0x0000.
REQ-023 FETCH: fetch_req=1 and fetch_ch=ch_cnt; on fetch_ack, drop fetch_req, pulse eng_start for exactly one cycle, go to CONV.
REQ-024 CONV: wait for eng_done.
REQ-025 CONV, eng_done with ch_cnt=0: psum<=eng_result, then go to FETCH, or to OUT if this is the last channel.
REQ-026 CONV, eng_done with ch_cnt>0: present psum and eng_result to the adder (one-cycle add_nd), go to ADD.
REQ-027 ADD: on add_rdy, psum<=add_result.
REQ-028 ADD, after the update: if ch_cnt==channels-1, go to OUT; otherwise increment ch_cnt and go to FETCH.
REQ-029 The channel counter does not wrap: a job of 2^CH_W-1 channels completes normally.
REQ-030 OUT: res_valid=1 and res_data=(relu && psum[15]) ? 0x0000 : psum.
REQ-031 OUT holds res_data stable while res_ready=0; on res_valid&res_ready, go to IDLE.
REQ-032 Watchdog: counts cycles spent in CONV or ADD and resets on every state entry.
REQ-033 When the watchdog reaches TIMEOUT: set err, drive res_data=0x0000, go to OUT.
REQ-034 Any eng_done or add_rdy that arrives outside CONV or ADD is ignored.
REQ-035 job_valid while busy is not accepted (job_ready=0).
REQ-036 An eng_done in the same cycle as the watchdog expiry is honoured; the timeout is not flagged.
REQ-037 Latency per channel: 1 cycle after fetch_ack to eng_start, plus the engine latency, plus the adder latency for every channel except the first.

Reset
REQ-038 On rst_n low, immediately and from any state, including mid-job: state=IDLE.
REQ-039 On rst_n low: job_ready=0 while reset is asserted and 1 after release.
REQ-040 On rst_n low: fetch_req, eng_start, res_valid, busy and err all 0.
REQ-041 On rst_n low: res_data, psum, ch_cnt and watchdog all 0; the adder handshake is idle.
REQ-042 No output pulses during the first cycle after reset release.

Structure
REQ-043 The shared package holds the state encoding, FP16_ZERO=16'h0000 and the default CH_W and TIMEOUT values.
REQ-044 One sub-module, conv_psum_add, wraps the fp16 accum core.
REQ-045 conv_psum_add ports: a, b, nd in; rdy, result out.
REQ-046 conv_psum_add drives ce=~rdy and sclr=rdy internally.

Verification
REQ-047 1-channel job, eng_result=0x3C00 -> res_data=0x3C00, no adder use, err=0.
REQ-048 3-channel job, each eng_result=0x3C00 -> fetch_ch sequence 0,1,2; res_data=0x4200.
REQ-049 2-channel job, relu=1, results 0xBC00 and 0xBC00 -> res_data=0x0000; with relu=0 -> 0xC000.
REQ-050 res_ready held low 20 cycles in OUT -> res_data stable, job_valid not accepted; accepted on the first cycle res_ready=1.
REQ-051 eng_done withheld -> err=1 and res_data=0x0000 exactly TIMEOUT cycles after CONV entry.
REQ-052 rst_n asserted mid-ADD -> all outputs 0 immediately; the next job (1 channel, 0x4000) completes with res_data=0x4000.
